axi_apb_master: RTL and testbench

AXI_APB_MASTER -- requirements
Module: axi_apb_master

---
 rtl/axi_apb_master_pkg.sv | 25 ++
 rtl/axi_apb_master.sv | 199 +++++++++++++++++++
 tb/tb_axi_apb_master.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_apb_master_pkg.sv
// Shared definitions for the AXI-Lite to APB3 master: FSM encoding, response codes, timeout default.
// Latency: not applicable (definitions only).
// Backpressure: not applicable.
package axi_apb_master_pkg;

    // One APB transfer in flight: accept, SETUP phase, ACCESS phase, AXI response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ACCESS-wait limit used when the APB_TIMEOUT_EN build is selected.
    localparam int APB_TIMEOUT_CYCLES_DFLT = 16;

    // AXI response code for a completed APB transfer.
    function automatic logic [1:0] resp_code(input logic slverr);
        return slverr ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_apb_master.sv
// AXI-Lite slave to APB3 master bridge, one transfer in flight, write/read round-robin (optional APB_TIMEOUT_EN ACCESS timeout).
// Latency: accept T, SETUP T+1, ACCESS T+2, B/R valid T+3 (pready=1), IDLE T+4; each pready=0 cycle adds one.
// Backpressure: AXI requests are held off outside IDLE; the response is held in RESP until bready/rready.
module axi_apb_master
    import axi_apb_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DFLT
) (
    input  logic              pclk,
    input  logic              presetn,
    // AXI-Lite write
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    // AXI-Lite read
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    // APB3 master
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t        r_state;
    apb_state_t        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_write;
    logic              r_slverr;
    // Set when the last served request was a write; 0 out of reset so a write wins the first tie.
    logic              r_last_wr;

    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_accept;
    logic              w_capture;
    logic              w_to_exit;
    logic              w_timeout;

    // A write needs address and data together; a lone AW or W must not stall a read.
    assign w_wr_elig  = awvalid & wvalid;
    assign w_rd_elig  = arvalid;
    assign w_grant_wr = w_wr_elig & (~w_rd_elig | ~r_last_wr);
    assign w_grant_rd = w_rd_elig & ~w_grant_wr;

`ifdef APB_TIMEOUT_EN
    localparam int TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_CNT_W-1:0] r_to_cnt;

    // Stalled-ACCESS counter: cleared in SETUP (always the cycle before ACCESS), counts pready=0 cycles.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !pready) begin
            r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    assign w_timeout = (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timeout: ACCESS waits for pready indefinitely.
    assign w_timeout = 1'b0;

    // The wait limit is still accepted so both builds share one parameter list.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
    end
`endif

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus handshake and APB phase outputs, all decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        awready      = 1'b0;
        wready       = 1'b0;
        arready      = 1'b0;
        psel         = 1'b0;
        penable      = 1'b0;
        bvalid       = 1'b0;
        rvalid       = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_to_exit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    awready      = 1'b1;
                    wready       = 1'b1;
                    w_accept     = 1'b1;
                    w_next_state = ST_SETUP;
                end else if (w_grant_rd) begin
                    arready      = 1'b1;
                    w_accept     = 1'b1;
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel         = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end else if (w_timeout) begin
                    w_to_exit    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (r_write) begin
                    bvalid = 1'b1;
                    if (bready) begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    rvalid = 1'b1;
                    if (rready) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture on acceptance, completion capture on pready (or forced error on timeout).
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_write   <= 1'b0;
            r_slverr  <= 1'b0;
            r_last_wr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write   <= w_grant_wr;
                r_last_wr <= w_grant_wr;
                r_addr    <= w_grant_wr ? awaddr : araddr;
                if (w_grant_wr) begin
                    r_wdata <= wdata;
                end
            end
            if (w_capture) begin
                r_rdata  <= prdata;
                r_slverr <= pslverr;
            end else if (w_to_exit) begin
                r_rdata  <= '0;
                r_slverr <= 1'b1;
            end
        end
    end

    assign paddr  = r_addr;
    assign pwrite = r_write;
    assign pwdata = r_wdata;
    assign rdata  = r_rdata;
    assign bresp  = bvalid ? resp_code(r_slverr) : RESP_OKAY;
    assign rresp  = rvalid ? resp_code(r_slverr) : RESP_OKAY;

endmodule

// File: tb/tb_axi_apb_master.sv
// Scoreboard bench for axi_apb_master: stimulus pushes expected APB phases and AXI responses, a monitor pops and compares.
// Latency: responses are checked against the expected accept-to-valid cycle count.
// Backpressure: bready/rready are held high; the APB responder inserts pready wait states per transaction.
module tb_axi_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          pclk    = 1'b0;
    logic          presetn = 1'b0;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [AW-1:0] awaddr, araddr, paddr;
    logic [DW-1:0] wdata, rdata, pwdata, prdata;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;
    logic          psel, penable, pwrite, pready, pslverr;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
    } apb_exp_t;

    typedef struct {
        bit          wr;
        logic [1:0]  rc;
        logic [31:0] rd;
        int          lat;
        int          acc;
    } rsp_exp_t;

    apb_exp_t    apb_q[$];
    rsp_exp_t    rsp_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          cfg_wait;
    logic [31:0] cfg_prdata;
    logic        cfg_slverr;

    axi_apb_master #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input string got_s, input string exp_s);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %s, expected %s", nm, got_s, exp_s);
    endtask

    task automatic exp_apb(input bit wr, input logic [31:0] a, input logic [31:0] d);
        apb_exp_t e;
        e.addr  = a;
        e.wr    = wr;
        e.wdata = d;
        apb_q.push_back(e);
    endtask

    task automatic exp_rsp(input bit wr, input logic [1:0] rc, input logic [31:0] rd,
                           input int lat, input int acc);
        rsp_exp_t r;
        r.wr  = wr;
        r.rc  = rc;
        r.rd  = rd;
        r.lat = lat;
        r.acc = acc;
        rsp_q.push_back(r);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (rsp_q.size() != 0 && k < 200) begin
            @(negedge pclk);
            k++;
        end
        if (rsp_q.size() != 0) begin
            flag("drain", "responses outstanding", "all responses seen");
            rsp_q.delete();
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] prd, input int wt, input bit err,
                           input logic [1:0] xrc, input logic [31:0] xrd,
                           input int xlat, input int xacc);
        bit got;
        got        = 1'b0;
        cfg_wait   = wt;
        cfg_prdata = prd;
        cfg_slverr = err;
        exp_apb(wr, a, d);
        exp_rsp(wr, xrc, xrd, xlat, xacc);
        if (wr) begin
            awaddr  = a;
            wdata   = d;
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end else begin
            araddr  = a;
            arvalid = 1'b1;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge pclk);
            if (wr ? (awready && wready) : arready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge pclk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        if (!got) flag("txn_accept", "no ready", "ready pulse");
        wait_drain();
    endtask

    // APB slave model: pready rises on access cycle cfg_wait+1 of each transfer.
    initial begin
        int acc_n;
        acc_n   = 0;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                pready = (acc_n == cfg_wait);
                acc_n++;
            end else begin
                pready = 1'b0;
                acc_n  = 0;
            end
            prdata  = cfg_prdata;
            pslverr = cfg_slverr;
        end
    end

    // Monitor: pops the scoreboard whenever an APB SETUP or an AXI response appears.
    initial begin
        apb_exp_t    e;
        rsp_exp_t    r;
        int          acc_cyc;
        int          acc_cnt;
        logic [31:0] cur_addr;
        acc_cyc  = 0;
        acc_cnt  = 0;
        cur_addr = '0;
        forever begin
            @(negedge pclk);
            if (presetn) begin
                if (penable) chk("penable_needs_psel", psel, 1);
                if (awready || wready) chk("aw_w_ready_pair", {awready, wready}, 2'b11);
                if ((awready && wready) || arready) acc_cyc = cyc;
                if (psel && !penable) begin
                    acc_cnt = 0;
                    if (apb_q.size() == 0) begin
                        flag("apb_unexpected", "SETUP phase", "no transfer");
                    end else begin
                        e        = apb_q.pop_front();
                        cur_addr = e.addr;
                        chk("setup_paddr", paddr, e.addr);
                        chk("setup_pwrite", pwrite, e.wr);
                        if (e.wr) chk("setup_pwdata", pwdata, e.wdata);
                    end
                end
                if (psel && penable) begin
                    acc_cnt++;
                    chk("access_paddr_hold", paddr, cur_addr);
                end
                if (bvalid || rvalid) begin
                    if (rsp_q.size() == 0) begin
                        flag("rsp_unexpected", "bvalid/rvalid", "no response");
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_bvalid", bvalid, r.wr);
                        chk("rsp_rvalid", rvalid, !r.wr);
                        if (r.wr) begin
                            chk("bresp", bresp, r.rc);
                        end else begin
                            chk("rresp", rresp, r.rc);
                            chk("rdata", rdata, r.rd);
                        end
                        chk("rsp_latency", cyc - acc_cyc, r.lat);
                        chk("access_cycles", acc_cnt, r.acc);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        bit   got;
        bit   seen;
        logic acc_w;
        logic acc_r;
        bit   got_w;
        bit   got_r;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        arvalid    = 1'b0;
        awaddr     = '0;
        araddr     = '0;
        wdata      = '0;
        bready     = 1'b1;
        rready     = 1'b1;
        cfg_wait   = 0;
        cfg_prdata = '0;
        cfg_slverr = 1'b0;

        // Reset state.
        repeat (2) @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        presetn = 1'b1;
        @(posedge pclk);
        #1;

        // Write and read both valid from reset, twice: write, read, write, read.
        cfg_prdata = 32'h0000_005A;
        for (int rnd = 0; rnd < 2; rnd++) begin
            exp_apb(1, 32'(32'h30 + rnd * 8), 32'(32'hC0DE_0000 + rnd));
            exp_rsp(1, 2'b00, 32'h0, 3, 1);
            exp_apb(0, 32'(32'h34 + rnd * 8), 32'h0);
            exp_rsp(0, 2'b00, 32'h0000_005A, 3, 1);
            awaddr  = 32'(32'h30 + rnd * 8);
            wdata   = 32'(32'hC0DE_0000 + rnd);
            araddr  = 32'(32'h34 + rnd * 8);
            awvalid = 1'b1;
            wvalid  = 1'b1;
            arvalid = 1'b1;
            got_w   = 1'b0;
            got_r   = 1'b0;
            for (int k = 0; k < 100 && !(got_w && got_r); k++) begin
                @(negedge pclk);
                acc_w = awready && wready;
                acc_r = arready;
                @(posedge pclk);
                #1;
                if (acc_w) begin
                    awvalid = 1'b0;
                    wvalid  = 1'b0;
                    got_w   = 1'b1;
                end
                if (acc_r) begin
                    arvalid = 1'b0;
                    got_r   = 1'b1;
                end
            end
            if (!(got_w && got_r)) flag("rr_accept", "request left pending", "both accepted");
            wait_drain();
        end

        // Single write, no wait states: bvalid three cycles after acceptance.
        run_txn(1, 32'h10, 32'hA5A5_0001, 32'h0, 0, 0, 2'b00, 32'h0, 3, 1);

        // Read with three pready=0 cycles: four ACCESS cycles.
        run_txn(0, 32'h14, 32'h0, 32'h0000_00C3, 3, 0, 2'b00, 32'h0000_00C3, 6, 4);

        // Slave error on a read, then a clean write.
        run_txn(0, 32'h18, 32'h0, 32'hDEAD_BEEF, 0, 1, 2'b10, 32'hDEAD_BEEF, 3, 1);
        run_txn(1, 32'h1C, 32'h1234_5678, 32'h0, 0, 0, 2'b00, 32'h0, 3, 1);

        // AW without W must not block a read; the write goes once W arrives.
        cfg_prdata = 32'h0000_0E0E;
        cfg_wait   = 0;
        cfg_slverr = 1'b0;
        exp_apb(0, 32'h20, 32'h0);
        exp_rsp(0, 2'b00, 32'h0000_0E0E, 3, 1);
        exp_apb(1, 32'h24, 32'h2424_2424);
        exp_rsp(1, 2'b00, 32'h0, 3, 1);
        awaddr  = 32'h24;
        wdata   = 32'h2424_2424;
        araddr  = 32'h20;
        awvalid = 1'b1;
        arvalid = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge pclk);
            if (arready) begin
                got = 1'b1;
                chk("partial_no_awready", awready, 0);
                break;
            end
        end
        if (!got) flag("partial_read_accept", "no arready", "arready pulse");
        @(posedge pclk);
        #1;
        arvalid = 1'b0;
        wvalid  = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge pclk);
            if (awready && wready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge pclk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!got) flag("partial_write_accept", "no awready", "awready pulse");
        wait_drain();

        // Reset during ACCESS: APB drops at once, no response afterwards.
        cfg_wait = 50;
        exp_apb(1, 32'h40, 32'h1111_2222);
        awaddr  = 32'h40;
        wdata   = 32'h1111_2222;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge pclk);
            if (awready && wready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge pclk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!got) flag("rst_txn_accept", "no awready", "awready pulse");
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge pclk);
            if (psel && penable) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag("rst_txn_access", "no ACCESS phase", "ACCESS phase");
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("rst_mid_psel", psel, 0);
        chk("rst_mid_penable", penable, 0);
        chk("rst_mid_bvalid", bvalid, 0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        repeat (6) @(negedge pclk);
        @(posedge pclk);
        #1;
        run_txn(1, 32'h44, 32'h0BAD_F00D, 32'h0, 0, 0, 2'b00, 32'h0, 3, 1);

`ifdef APB_TIMEOUT_EN
        // pready never rises: exit after TO ACCESS cycles with SLVERR and zero data.
        run_txn(0, 32'h50, 32'h0, 32'h0000_0077, 1000, 0, 2'b10, 32'h0, 3 + TO - 1, TO);
        run_txn(1, 32'h54, 32'h5555_AAAA, 32'h0, 0, 0, 2'b00, 32'h0, 3, 1);
`endif

        if (apb_q.size() != 0) flag("apb_leftover", "unseen SETUP phases", "none");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
